// File: rtl/board_gen_param.sv
// Parametrised Lights-Out board generator: preset boards from a selector,
// random boards from an LFSR-driven scramble of legal presses.
module board_gen_param #(
    parameter int unsigned ROWS       = 3,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SEL_W      = 5,
    parameter int unsigned SCRAMBLE_M = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       num,
    input  logic                   random,
    input  logic [1:0]             game_status,
    output logic [ROWS*COLS-1:0]   board,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned N         = ROWS * COLS;
    localparam int unsigned CNT_W     = $clog2(SCRAMBLE_M + 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [1:0]  CHOSE     = 2'b00;
    localparam logic [N-1:0] ONE      = N'(1);

    typedef enum logic {IDLE, SCRAMBLE} state_t;

    // Cells toggled by pressing cell k: itself plus in-grid orthogonal neighbours.
    function automatic logic [N-1:0] press_mask(input int unsigned k);
        logic [N-1:0] m;
        int unsigned  r;
        int unsigned  c;
        r = k / COLS;
        c = k % COLS;
        m = ONE << k;
        if (r > 0)        m = m | (ONE << (k - COLS));
        if (r < ROWS - 1) m = m | (ONE << (k + COLS));
        if (c > 0)        m = m | (ONE << (k - 1));
        if (c < COLS - 1) m = m | (ONE << (k + 1));
        return m;
    endfunction

    // Preset board: XOR of the presses selected by each set bit of sel.
    function automatic logic [N-1:0] preset(input logic [SEL_W-1:0] sel);
        logic [N-1:0]     m;
        logic [SEL_W-1:0] s;
        m = '0;
        s = sel;
        for (int unsigned i = 0; i < SEL_W; i++) begin
            if (s[0]) m = m ^ press_mask(i);
            s = s >> 1;
        end
        return m;
    endfunction

    // Galois LFSR step; the mask keeps the sequence maximal and never zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
    endfunction

    state_t             state, state_n;
    logic [N-1:0]       board_n, scr_board;
    logic               busy_n, done_n;
    logic               hold, hold_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [15:0]        lfsr, lfsr_n;
    logic               random_q;
    logic [SEL_W-1:0]   num_q;
    logic               rise;

    assign rise      = random & ~random_q;
    assign scr_board = board ^ press_mask(32'(lfsr[7:0]) % N);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            board    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hold     <= 1'b0;
            cnt      <= '0;
            lfsr     <= LFSR_SEED;
            random_q <= 1'b1;
            num_q    <= '0;
        end else begin
            state    <= state_n;
            board    <= board_n;
            busy     <= busy_n;
            done     <= done_n;
            hold     <= hold_n;
            cnt      <= cnt_n;
            lfsr     <= lfsr_n;
            random_q <= random;
            num_q    <= num;
        end
    end

    // Next-state logic: preset tracking in IDLE, one random press per cycle in SCRAMBLE.
    always_comb begin
        state_n = state;
        board_n = board;
        busy_n  = busy;
        done_n  = 1'b0;
        hold_n  = hold;
        cnt_n   = cnt;
        lfsr_n  = lfsr_step(lfsr);
        case (state)
            IDLE: begin
                if (game_status == CHOSE) begin
                    if (rise) begin
                        board_n = '0;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                        state_n = SCRAMBLE;
                    end else if (!hold) begin
                        board_n = preset(num);
                    end else if (num != num_q) begin
                        hold_n  = 1'b0;
                        board_n = preset(num);
                    end
                end
            end
            SCRAMBLE: begin
                board_n = scr_board;
                if (cnt < CNT_W'(SCRAMBLE_M)) cnt_n = cnt + CNT_W'(1);
                // Keep pressing past the nominal count until the board is non-empty.
                if ((cnt_n == CNT_W'(SCRAMBLE_M)) && (scr_board != '0)) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    hold_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_board_gen_param.sv
// Self-checking bench for board_gen_param (3x4 board, 16-press scramble).
module tb_board_gen_param;

    localparam int unsigned ROWS  = 3;
    localparam int unsigned COLS  = 4;
    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned M     = 16;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct {
        logic [N-1:0] board;
        int           width;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [SEL_W-1:0] num;
    logic             random;
    logic [1:0]       game_status;
    logic [N-1:0]     board;
    logic             busy;
    logic             done;

    logic [15:0]      lfsr_m;
    exp_t             sb[$];
    int               checks = 0;
    int               fails  = 0;
    logic [N-1:0]     held;
    logic             stable;

    board_gen_param #(
        .ROWS(ROWS), .COLS(COLS), .SEL_W(SEL_W), .SCRAMBLE_M(M), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .num(num), .random(random),
        .game_status(game_status), .board(board), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, free-running like the generator's.
    always @(posedge clk) begin
        if (!rst) lfsr_m <= SEED;
        else      lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Cells within Manhattan distance 1 of cell k.
    function automatic logic [N-1:0] ref_press(input int k);
        logic [N-1:0] m;
        int kr, kc, jr, jc, d;
        m  = '0;
        kr = k / COLS;
        kc = k % COLS;
        for (int j = 0; j < N; j++) begin
            jr = j / COLS;
            jc = j % COLS;
            d  = ((jr > kr) ? jr - kr : kr - jr) + ((jc > kc) ? jc - kc : kc - jc);
            if (d <= 1) m = m | (N'(1) << j);
        end
        return m;
    endfunction

    // Expected scramble outcome given the LFSR value at the accepting edge.
    function automatic exp_t ref_scramble(input logic [15:0] l0);
        exp_t         e;
        logic [15:0]  l;
        logic [N-1:0] b;
        int           n;
        l = l0;
        b = '0;
        n = 0;
        while ((n < M || b == '0) && n < 1000) begin
            l = ref_step(l);
            b = b ^ ref_press(int'(l[7:0]) % N);
            n++;
        end
        e.board = b;
        e.width = n;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle random pulse, driven from a falling edge; returns one cycle later.
    task automatic pulse_random(input bit expect_start);
        random = 1'b1;
        if (expect_start) sb.push_back(ref_scramble(lfsr_m));
        @(negedge clk);
        random = 1'b0;
    endtask

    // Wait for done, count busy cycles, and compare against the scoreboard head.
    task automatic wait_done(input string tag, input int pre);
        int   cyc;
        bit   got;
        exp_t e;
        cyc = pre;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) cyc++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
            check({tag, "_board"}, 32'(board), 32'(e.board));
            check({tag, "_board_nonzero"}, 32'(board != '0), 32'd1);
            check({tag, "_busy_width"}, 32'(cyc), 32'(e.width));
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        rst         = 1'b0;
        random      = 1'b1;
        num         = '0;
        game_status = 2'b00;

        // Reset with the button held.
        repeat (3) @(negedge clk);
        check("reset_board", 32'(board), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_done",  32'(done),  32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("held_btn_busy",  32'(busy),  32'h0);
        check("held_btn_board", 32'(board), 32'h0);
        random = 1'b0;
        @(negedge clk);

        // Presets with one-cycle latency.
        num = 5'b00011; @(negedge clk);
        check("preset_00011", 32'(board), 32'h034);
        num = 5'b10001; @(negedge clk);
        check("preset_10001", 32'(board), 32'h122);
        num = 5'b00001; @(negedge clk);
        check("preset_00001", 32'(board), 32'h013);

        // Random scramble.
        pulse_random(1'b1);
        check("scr1_busy_rise", 32'(busy), 32'h1);
        wait_done("scr1", 0);

        // Random board holds while num is unchanged, then preset returns.
        held   = board;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (board !== held) stable = 1'b0;
        end
        check("hold_50_cycles", 32'(stable), 32'h1);
        num = 5'b00011; @(negedge clk);
        check("preset_after_hold", 32'(board), 32'h034);

        // Extra pulse during scramble is ignored.
        pulse_random(1'b1);
        @(negedge clk);
        random = 1'b1;
        @(negedge clk);
        random = 1'b0;
        wait_done("scr2", 2);

        // Leaving board selection mid-scramble: scramble completes, then freezes.
        num = 5'b00001; @(negedge clk);
        check("preset_before_scr3", 32'(board), 32'h013);
        pulse_random(1'b1);
        @(negedge clk);
        game_status = 2'b01;
        wait_done("scr3", 1);
        held = board;
        num  = 5'b10101;
        pulse_random(1'b0);
        repeat (3) @(negedge clk);
        num  = 5'b00111;
        repeat (3) @(negedge clk);
        check("gaming_board_frozen", 32'(board), 32'(held));
        check("gaming_busy_low",     32'(busy),  32'h0);
        game_status = 2'b00;
        repeat (2) @(negedge clk);
        check("chose_hold_kept", 32'(board), 32'(held));
        num = 5'b10001; @(negedge clk);
        check("chose_preset_resumes", 32'(board), 32'h122);

        // Reset in the middle of a scramble.
        pulse_random(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_board", 32'(board), 32'h0);
        check("midreset_busy",  32'(busy),  32'h0);
        check("midreset_done",  32'(done),  32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("postreset_preset", 32'(board), 32'h122);
        check("postreset_busy",   32'(busy),  32'h0);

        // Scramble after reset follows the reseeded LFSR.
        pulse_random(1'b1);
        wait_done("scr4", 0);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
